// File: rtl/hilo_fwd_unit.sv
// hilo_fwd_unit: HI/LO architectural registers for the MIPS core, with an
// NUM_FWD-deep forwarding network for mfhi/mflo and a tracker for one
// multi-cycle multiply/divide. Sits beside the EX stage.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   rd_hi_req, rd_lo_req       EX-stage instruction reads HI / LO
//   fwd_hi_we, fwd_lo_we       per-stage pending writes, bit i = stage i (0 = youngest)
//   fwd_hi_data, fwd_lo_data   per-stage values, stage i at [i*DATA_W +: DATA_W]
//   md_start                   launch multiply/divide (ignored while busy)
//   md_hi_res, md_lo_res       multiply/divide result, sampled on the completion edge
//   hi_out, lo_out             forwarded HI / LO value to EX
//   md_busy                    multiply/divide in flight
//   stall                      freeze IF/ID/EX this cycle
//   stall_cnt                  saturating count of stalled cycles (HILO_STALL_CNT_EN only)
//
// Optional feature: define HILO_STALL_CNT_EN to add the stall_cnt output.

module hilo_fwd_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned MD_LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_hi_req,
    input  logic                      rd_lo_req,
    input  logic [NUM_FWD-1:0]        fwd_hi_we,
    input  logic [NUM_FWD-1:0]        fwd_lo_we,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_hi_data,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_lo_data,
    input  logic                      md_start,
    input  logic [DATA_W-1:0]         md_hi_res,
    input  logic [DATA_W-1:0]         md_lo_res,
    output logic [DATA_W-1:0]         hi_out,
    output logic [DATA_W-1:0]         lo_out,
    output logic                      md_busy,
    output logic                      stall
`ifdef HILO_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int unsigned CommitStage = NUM_FWD - 1;
    localparam logic [7:0]  MdLatCnt    = 8'(MD_LAT);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [7:0]        md_cnt_q, md_cnt_d;
    logic              md_done;

    // Forwarding: walk from oldest to youngest so the lowest-index hit wins.
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_hi_we[i]) hi_out = fwd_hi_data[i*DATA_W +: DATA_W];
            if (fwd_lo_we[i]) lo_out = fwd_lo_data[i*DATA_W +: DATA_W];
        end
    end

    assign md_busy = (md_cnt_q != 8'd0);
    assign stall   = md_busy & (rd_hi_req | rd_lo_req);
    assign md_done = (md_cnt_q == 8'd1);

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_cnt_d = md_cnt_q;

        // Commit-stage writes; HI and LO independent for mthi/mtlo.
        if (fwd_hi_we[CommitStage]) hi_d = fwd_hi_data[CommitStage*DATA_W +: DATA_W];
        if (fwd_lo_we[CommitStage]) lo_d = fwd_lo_data[CommitStage*DATA_W +: DATA_W];

        // Multiply/divide completion overrides a same-edge commit write.
        if (md_done) begin
            hi_d = md_hi_res;
            lo_d = md_lo_res;
        end

        // A start while busy is a protocol violation and is dropped.
        if (md_cnt_q == 8'd0) begin
            if (md_start) md_cnt_d = MdLatCnt;
        end else begin
            md_cnt_d = md_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            md_cnt_q <= 8'd0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HILO_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hilo_fwd_unit.sv
module tb_hilo_fwd_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned NF  = 2;
    localparam int unsigned LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_hi_req, rd_lo_req;
    logic [NF-1:0]     fwd_hi_we, fwd_lo_we;
    logic [NF*DW-1:0]  fwd_hi_data, fwd_lo_data;
    logic              md_start;
    logic [DW-1:0]     md_hi_res, md_lo_res;
    logic [DW-1:0]     hi_out, lo_out;
    logic              md_busy, stall;
`ifdef HILO_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural registers plus the cycle at which the
    // in-flight operation completes.
    logic [DW-1:0] m_hi, m_lo;
    bit            m_md_act;
    int            m_end;
    int            cyc;
    longint        m_scnt;

    always #5 clk = ~clk;

    hilo_fwd_unit #(
        .DATA_W  (DW),
        .NUM_FWD (NF),
        .MD_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_hi_req   (rd_hi_req),
        .rd_lo_req   (rd_lo_req),
        .fwd_hi_we   (fwd_hi_we),
        .fwd_lo_we   (fwd_lo_we),
        .fwd_hi_data (fwd_hi_data),
        .fwd_lo_data (fwd_lo_data),
        .md_start    (md_start),
        .md_hi_res   (md_hi_res),
        .md_lo_res   (md_lo_res),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .md_busy     (md_busy),
        .stall       (stall)
`ifdef HILO_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [NF-1:0] we, input logic [NF*DW-1:0] d,
                                           input logic [DW-1:0] r);
        for (int i = 0; i < int'(NF); i++) begin
            if (we[i]) return d[i*DW +: DW];
        end
        return r;
    endfunction

    function automatic bit m_busy();
        return m_md_act && (cyc <= m_end);
    endfunction

    task automatic model_reset();
        m_hi     = '0;
        m_lo     = '0;
        m_md_act = 1'b0;
        m_scnt   = 0;
    endtask

    task automatic check_outputs();
        bit b;
        b = m_busy();
        check("hi_out", 64'(hi_out), 64'(pick(fwd_hi_we, fwd_hi_data, m_hi)));
        check("lo_out", 64'(lo_out), 64'(pick(fwd_lo_we, fwd_lo_data, m_lo)));
        check("md_busy", 64'(md_busy), 64'(b));
        check("stall", 64'(stall), 64'(b && (rd_hi_req || rd_lo_req)));
`ifdef HILO_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
`endif
    endtask

    // Check outputs, clock one edge, advance the model, return at the next negedge.
    task automatic tick();
        bit b;
        #1;
        check_outputs();
        b = m_busy();
        @(posedge clk);
        if (!rst) begin
            if (fwd_hi_we[NF-1]) m_hi = fwd_hi_data[(NF-1)*DW +: DW];
            if (fwd_lo_we[NF-1]) m_lo = fwd_lo_data[(NF-1)*DW +: DW];
            if (m_md_act && cyc == m_end) begin
                m_hi     = md_hi_res;
                m_lo     = md_lo_res;
                m_md_act = 1'b0;
            end
            if (md_start && b) begin
                n_checks++;
                n_errors++;
                $display("FAIL proto: md_start issued while busy (t=%0t)", $time);
            end
            if (!b && md_start) begin
                m_md_act = 1'b1;
                m_end    = cyc + int'(LAT);
            end
            if (b && (rd_hi_req || rd_lo_req) && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rd_hi_req   = 1'b0;
        rd_lo_req   = 1'b0;
        fwd_hi_we   = '0;
        fwd_lo_we   = '0;
        fwd_hi_data = '0;
        fwd_lo_data = '0;
        md_start    = 1'b0;
        md_hi_res   = '0;
        md_lo_res   = '0;
    endtask

    // Reset asserted at a negedge; outputs must respond without a clock edge.
    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_busy", 64'(md_busy), 64'd0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0;
        m_end = 0;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        rd_hi_req = 1'b1;
        #1;
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_md_busy", 64'(md_busy), 64'd0);
        tick();

        // Commit-stage HI write leaves LO alone.
        fwd_hi_we = 2'b10;
        fwd_hi_data[DW +: DW] = 32'h1234_5678;
        tick();
        clear_inputs();
        #1;
        check("commit_hi", 64'(hi_out), 64'h1234_5678);
        check("commit_lo", 64'(lo_out), 64'd0);

        // Forwarding priority.
        fwd_hi_we = 2'b10;
        fwd_hi_data[DW +: DW] = 32'h1;
        tick();
        fwd_hi_we = 2'b11;
        fwd_hi_data = {32'hBBBB_0000, 32'hAAAA_0000};
        #1;
        check("prio_stage0", 64'(hi_out), 64'hAAAA_0000);
        fwd_hi_we = 2'b10;
        #1;
        check("prio_stage1", 64'(hi_out), 64'hBBBB_0000);
        clear_inputs();
        tick();

        // Multiply/divide: stall for exactly LAT cycles, then result visible.
        md_start  = 1'b1;
        md_hi_res = 32'hDEAD;
        md_lo_res = 32'hBEEF;
        rd_lo_req = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            #1;
            check("md_stall_on", 64'(stall), 64'd1);
            tick();
        end
        #1;
        check("md_stall_off", 64'(stall), 64'd0);
        check("md_lo", 64'(lo_out), 64'hBEEF);
        check("md_hi", 64'(hi_out), 64'hDEAD);
`ifdef HILO_STALL_CNT_EN
        check("stall_cnt_md", 64'(stall_cnt), 64'd4);
`endif
        clear_inputs();

        // Completion collides with a commit-stage HI write: MD result wins.
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < int'(LAT) - 1; i++) tick();
        fwd_hi_we = 2'b10;
        fwd_hi_data[DW +: DW] = 32'h5555;
        md_hi_res = 32'h1111;
        md_lo_res = 32'h2222;
        tick();
        clear_inputs();
        #1;
        check("conflict_hi", 64'(hi_out), 64'h1111);
        check("conflict_lo", 64'(lo_out), 64'h2222);

        // Reset two cycles into an operation discards it.
        md_start  = 1'b1;
        md_hi_res = 32'h7777;
        md_lo_res = 32'h8888;
        tick();
        md_start = 1'b0;
        tick();
        pulse_reset();
        for (int i = 0; i < int'(LAT) + 1; i++) tick();
        #1;
        check("midrst_hi", 64'(hi_out), 64'd0);
        check("midrst_lo", 64'(lo_out), 64'd0);
        check("midrst_busy", 64'(md_busy), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end
            rd_hi_req   = 1'($urandom);
            rd_lo_req   = 1'($urandom);
            fwd_hi_we   = NF'($urandom);
            fwd_lo_we   = NF'($urandom);
            fwd_hi_data = {$urandom, $urandom};
            fwd_lo_data = {$urandom, $urandom};
            md_start    = !m_busy() && ($urandom_range(0, 3) == 0);
            md_hi_res   = $urandom;
            md_lo_res   = $urandom;
            tick();
        end
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_fwd_unit.md
Name: hilo_fwd_unit

Overview:
- Parametrised HI/LO register block for the MIPS core.
- Holds the HI and LO architectural registers and a configurable-depth forwarding network for mfhi/mflo.
- Tracks a multi-cycle multiply/divide operation and commits its result into HI/LO on completion.
- Raises a stall while an mfhi/mflo is issued against a pending multiply/divide; sits beside the EX stage.

Parameters:
- DATA_W, 32, width of HI, LO and all data ports.
- NUM_FWD, 2, number of forwarding stages; stage 0 youngest (MEM), stage NUM_FWD-1 oldest (WB, the commit stage).
- MD_LAT, 4, cycles from md_start edge to result commit; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_hi_req  in  1  EX-stage instruction reads HI (mfhi).
- rd_lo_req  in  1  EX-stage instruction reads LO (mflo).
- fwd_hi_we  in  NUM_FWD  per-stage HI write pending; bit i = stage i.
- fwd_lo_we  in  NUM_FWD  per-stage LO write pending.
- fwd_hi_data  in  NUM_FWD*DATA_W  per-stage HI value; stage i at bits [i*DATA_W +: DATA_W].
- fwd_lo_data  in  NUM_FWD*DATA_W  per-stage LO value, same packing.
- md_start  in  1  launch multiply/divide.
- md_hi_res  in  DATA_W  multiply/divide HI result; valid on the completion edge.
- md_lo_res  in  DATA_W  multiply/divide LO result; valid on the completion edge.
- hi_out  out  DATA_W  forwarded HI value to EX.
- lo_out  out  DATA_W  forwarded LO value to EX.
- md_busy  out  1  multiply/divide in flight.
- stall  out  1  freeze IF/ID/EX this cycle.

Behaviour:
- Reset (async, rst=1): hi_reg=0, lo_reg=0, md_cnt=0. Outputs follow combinationally: md_busy=0, stall=0, hi_out/lo_out = forwarded or zero register value.
- Read path (combinational, zero latency):
  - hi_out = fwd_hi_data of the lowest-index stage i with fwd_hi_we[i]=1; else hi_reg.
  - lo_out is independent of hi_out, same rule using fwd_lo_we/fwd_lo_data.
  - Outputs are driven regardless of rd_*_req.
- Commit: on each rising edge, fwd_hi_we[NUM_FWD-1]=1 writes hi_reg; fwd_lo_we[NUM_FWD-1]=1 writes lo_reg. HI and LO are written independently (mthi/mtlo partial writes).
- MD counter, 8-bit md_cnt:
  - md_start=1 and md_cnt==0 at an edge -> md_cnt<=MD_LAT.
  - md_cnt>1 -> md_cnt decrements each edge.
  - md_cnt==1 -> at that edge hi_reg<=md_hi_res, lo_reg<=md_lo_res, md_cnt<=0.
- md_busy = (md_cnt != 0). Asserted for exactly MD_LAT cycles after the start edge.
- stall = md_busy & (rd_hi_req | rd_lo_req). Combinational.
- md_start while md_busy: ignored; the counter is not reloaded. The pipeline must not issue it, and the bench flags it as a protocol error.
- Simultaneous MD completion and commit-stage write to the same register: the MD result wins. The non-conflicting half still takes the commit write.
- md_start and MD completion in the same cycle cannot occur (completion implies busy).
- Reset mid-operation: counter cleared, result discarded, md_busy falls immediately.
- No data-width arithmetic; values pass through unmodified.

Optional Feature:
- Macro: HILO_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), reset to 0.
  - Increments by 1 on every rising edge where stall=1; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then rd_hi_req=1 with no fwd_*_we -> hi_out=0, lo_out=0, stall=0, md_busy=0.
- Commit fwd_hi_we[1]=1, data 0x12345678, one edge, fwd cleared -> hi_out=0x12345678, lo_out unchanged at 0.
- Priority:
  - Setup: hi_reg=0x1, fwd_hi_we=2'b11, stage0=0xAAAA0000, stage1=0xBBBB0000 -> hi_out=0xAAAA0000.
  - Drop stage0 -> hi_out=0xBBBB0000.
- MD, MD_LAT=4:
  - Stimulus: md_start pulse; md_hi_res=0xDEAD, md_lo_res=0xBEEF held; rd_lo_req=1.
  - Response: stall=1 for exactly 4 cycles; then stall=0 and lo_out=0xBEEF, hi_out=0xDEAD.
- Conflict: at the MD completion edge, fwd_hi_we[1]=1 with 0x5555 and fwd_lo_we[1]=0 -> hi_reg=md_hi_res, lo_reg=md_lo_res.
- Mid-op reset and stall counter:
  - rst pulse 2 cycles after md_start -> md_busy=0 immediately, hi/lo=0, no later commit.
  - With HILO_STALL_CNT_EN, the prior MD scenario -> stall_cnt=4.
